// File: rtl/vdec_crc_check_gen.sv
// Parametrised CRC checker: folds BPC frame bits per clock through an LFSR and
// reports match when the final remainder is zero.
module vdec_crc_check_gen #(
  parameter int unsigned      CRC_W   = 16,
  parameter logic [CRC_W-1:0] POLY    = 16'h1021,
  parameter logic [CRC_W-1:0] INIT    = '0,
  parameter int unsigned      MAX_LEN = 37,
  parameter int unsigned      LEN_W   = 6,
  parameter int unsigned      BPC     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [MAX_LEN-1:0] check_bits,
  input  logic [LEN_W-1:0]   check_len,
  output logic               busy,
  output logic               done,
  output logic               crc_match,
  output logic               len_err,
  output logic [CRC_W-1:0]   crc_rem
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FIN} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [MAX_LEN-1:0] r_cache;
  logic [CRC_W-1:0]   r_crc;
  logic [LEN_W-1:0]   r_rem_cnt;
  logic               r_done;
  logic               r_crc_match;
  logic               r_len_err;
  logic [CRC_W-1:0]   r_crc_rem;

  logic               w_len_ok;
  logic [LEN_W-1:0]   w_n;
  logic [CRC_W-1:0]   w_crc_next;
  logic [MAX_LEN-1:0] w_cache_next;
  logic [LEN_W-1:0]   w_rem_next;

  assign w_len_ok = (check_len != '0) && (check_len <= LEN_W'(MAX_LEN));

  // Fold up to BPC bits; the final short group only consumes what is left.
  always_comb begin
    w_n        = (r_rem_cnt < LEN_W'(BPC)) ? r_rem_cnt : LEN_W'(BPC);
    w_crc_next = r_crc;
    for (int unsigned i = 0; i < BPC; i++) begin
      if (LEN_W'(i) < w_n) begin
        w_crc_next = {w_crc_next[CRC_W-2:0], 1'b0}
                   ^ ((r_cache[i] ^ w_crc_next[CRC_W-1]) ? POLY : '0);
      end
    end
    w_cache_next = r_cache >> w_n;
    w_rem_next   = r_rem_cnt - w_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (abort) begin
      w_state_next = S_IDLE;
    end else if (start) begin
      w_state_next = w_len_ok ? S_SHIFT : S_FIN;
    end else begin
      case (r_state)
        S_SHIFT: if (w_rem_next == '0) w_state_next = S_FIN;
        S_FIN:   w_state_next = S_IDLE;
        default: w_state_next = r_state;
      endcase
    end
  end

  // Results are registered on the edge entering FIN so they coincide with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cache     <= '0;
      r_crc       <= '0;
      r_rem_cnt   <= '0;
      r_done      <= 1'b0;
      r_crc_match <= 1'b0;
      r_len_err   <= 1'b0;
      r_crc_rem   <= '0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_crc_match <= 1'b0;
        r_len_err   <= 1'b0;
      end else if (start) begin
        r_cache     <= check_bits;
        r_crc       <= INIT;
        r_rem_cnt   <= check_len;
        r_crc_match <= 1'b0;
        r_len_err   <= ~w_len_ok;
        if (!w_len_ok) begin
          r_done    <= 1'b1;
          r_crc_rem <= '0;
        end
      end else if (r_state == S_SHIFT) begin
        r_cache   <= w_cache_next;
        r_crc     <= w_crc_next;
        r_rem_cnt <= w_rem_next;
        if (w_rem_next == '0) begin
          r_done      <= 1'b1;
          r_crc_match <= (w_crc_next == '0);
          r_crc_rem   <= w_crc_next;
        end
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign crc_match = r_crc_match;
  assign len_err   = r_len_err;
  assign crc_rem   = r_crc_rem;

endmodule

// File: tb/tb_vdec_crc_check_gen.sv
// Bench for vdec_crc_check_gen: BPC=1 and BPC=4 instances share stimulus and are
// checked against a polynomial long-division model of the CRC.
module tb_vdec_crc_check_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [36:0] check_bits = '0;
  logic [5:0]  check_len = '0;
  logic [1:0]  busy_v, done_v, match_v, lerr_v;
  logic [15:0] rem_v [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vdec_crc_check_gen #(
    .CRC_W(16), .POLY(16'h1021), .INIT(16'h0000), .MAX_LEN(37), .LEN_W(6), .BPC(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .check_bits(check_bits), .check_len(check_len),
    .busy(busy_v[0]), .done(done_v[0]), .crc_match(match_v[0]),
    .len_err(lerr_v[0]), .crc_rem(rem_v[0])
  );

  vdec_crc_check_gen #(
    .CRC_W(16), .POLY(16'h1021), .INIT(16'h0000), .MAX_LEN(37), .LEN_W(6), .BPC(4)
  ) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .check_bits(check_bits), .check_len(check_len),
    .busy(busy_v[1]), .done(done_v[1]), .crc_match(match_v[1]),
    .len_err(lerr_v[1]), .crc_rem(rem_v[1])
  );

  // Remainder of M(x)*x^16 mod G(x); bit 0 of the frame is the highest-degree term.
  function automatic logic [15:0] model_rem(input logic [36:0] bits, input int len);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < len; i++) v = (v << 1) | 64'(bits[i]);
    v = v << 16;
    for (int d = len + 15; d >= 16; d--)
      if (v[d]) v = v ^ (64'h11021 << (d - 16));
    return v[15:0];
  endfunction

  task automatic run_frame(input logic [36:0] bits, input logic [5:0] len, input string tag);
    logic        exp_le, exp_m;
    logic [15:0] exp_rem;
    int          exp_lat [2];
    int          d_at [2];
    int          d_cnt [2];
    int          b_err [2];
    logic        m_at [2];
    logic        le_at [2];
    logic [15:0] r_at [2];
    exp_le     = (len == 0) || (len > 37);
    exp_rem    = exp_le ? 16'h0 : model_rem(bits, int'(len));
    exp_m      = !exp_le && (exp_rem == 16'h0);
    exp_lat[0] = exp_le ? 1 : 1 + int'(len);
    exp_lat[1] = exp_le ? 1 : 1 + (int'(len) + 3) / 4;
    for (int u = 0; u < 2; u++) begin
      d_at[u] = 0; d_cnt[u] = 0; b_err[u] = 0;
      m_at[u] = 1'bx; le_at[u] = 1'bx; r_at[u] = 'x;
    end
    @(negedge clk);
    start = 1'b1; check_bits = bits; check_len = len;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        if (done_v[u]) begin
          d_cnt[u]++; d_at[u] = k;
          m_at[u] = match_v[u]; le_at[u] = lerr_v[u]; r_at[u] = rem_v[u];
        end
        if (busy_v[u] !== (k <= exp_lat[u])) b_err[u]++;
      end
      if (k == 1) begin
        start = 1'b0; check_bits = 37'({$urandom, $urandom}); check_len = 6'($urandom);
      end
    end
    for (int u = 0; u < 2; u++) begin
      n_vec++; if (d_cnt[u] !== 1) begin n_err++;
        $display("FAIL %s dut%0d done_count got %0d want 1", tag, u, d_cnt[u]); end
      n_vec++; if (d_at[u] !== exp_lat[u]) begin n_err++;
        $display("FAIL %s dut%0d done_latency got %0d want %0d", tag, u, d_at[u], exp_lat[u]); end
      n_vec++; if (m_at[u] !== exp_m) begin n_err++;
        $display("FAIL %s dut%0d crc_match got %b want %b", tag, u, m_at[u], exp_m); end
      n_vec++; if (le_at[u] !== exp_le) begin n_err++;
        $display("FAIL %s dut%0d len_err got %b want %b", tag, u, le_at[u], exp_le); end
      n_vec++; if (r_at[u] !== exp_rem) begin n_err++;
        $display("FAIL %s dut%0d crc_rem got %h want %h", tag, u, r_at[u], exp_rem); end
      n_vec++; if (b_err[u] !== 0) begin n_err++;
        $display("FAIL %s dut%0d busy_window got %0d bad cycles want 0", tag, u, b_err[u]); end
      n_vec++; if ({match_v[u], rem_v[u]} !== {exp_m, exp_rem}) begin n_err++;
        $display("FAIL %s dut%0d held_result got %b/%h want %b/%h", tag, u,
                 match_v[u], rem_v[u], exp_m, exp_rem); end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      n_vec++;
      if ({busy_v[u], done_v[u], match_v[u], lerr_v[u], rem_v[u]} !== 20'h0) begin
        n_err++;
        $display("FAIL reset dut%0d outputs got %b%b%b%b/%h want all 0", u,
                 busy_v[u], done_v[u], match_v[u], lerr_v[u], rem_v[u]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_known();
    run_frame(37'h0, 6'd37, "zeros37");
    run_frame(37'h10811, 6'd17, "poly17");
    run_frame(37'h10819, 6'd17, "poly17_flip3");
  endtask

  task automatic test_len_err();
    run_frame(37'h10811, 6'd0, "len0");
    run_frame(37'h10811, 6'd38, "len38");
    run_frame(37'h1FFFFFFFFF, 6'd63, "len63");
  endtask

  task automatic test_random();
    int          k, idx;
    logic [36:0] b;
    logic [15:0] c;
    for (int n = 0; n < 16; n++) begin
      k = $urandom_range(1, 21);
      b = 37'({$urandom, $urandom}) & ((37'd1 << k) - 37'd1);
      c = model_rem(b, k);
      for (int j = 0; j < 16; j++) b[k + j] = c[15 - j];
      if ($urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, k + 15);
        b[idx] = ~b[idx];
      end
      run_frame(b, 6'(k + 16), "rand_crc");
    end
    for (int n = 0; n < 8; n++)
      run_frame(37'({$urandom, $urandom}), 6'($urandom_range(1, 37)), "rand_raw");
  endtask

  task automatic test_abort();
    int bad;
    run_frame(37'h0, 6'd37, "abort_pre");
    @(negedge clk); start = 1'b1; check_bits = 37'({$urandom, $urandom}); check_len = 6'd37;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    n_vec++; if (busy_v !== 2'b00) begin n_err++;
      $display("FAIL abort busy_after got %b want 00", busy_v); end
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_v !== 2'b00 || busy_v !== 2'b00 || match_v !== 2'b00) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++;
      $display("FAIL abort quiet got %0d bad cycles want 0", bad); end
    bad = 0;
    @(negedge clk); abort = 1'b1; start = 1'b1; check_bits = 37'h10811; check_len = 6'd17;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (k == 0) begin abort = 1'b0; start = 1'b0; end
      if (done_v !== 2'b00 || busy_v !== 2'b00) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++;
      $display("FAIL abort_start stays_idle got %0d bad cycles want 0", bad); end
    run_frame(37'h10811, 6'd17, "abort_idle_pre");
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    n_vec++; if ({match_v, busy_v, done_v} !== 6'b0) begin n_err++;
      $display("FAIL abort_idle got match=%b busy=%b done=%b want 0", match_v, busy_v, done_v); end
  endtask

  task automatic test_back_to_back();
    int bad;
    bad = 0;
    @(negedge clk); start = 1'b1; check_bits = 37'({$urandom, $urandom}); check_len = 6'd37;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done_v !== 2'b00 || busy_v !== 2'b11) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++;
      $display("FAIL restart first_frame got %0d bad cycles want 0", bad); end
    run_frame(37'h10811, 6'd17, "restart");
  endtask

  task automatic test_reset_mid();
    run_frame(37'h10819, 6'd17, "rst_pre");
    @(negedge clk); start = 1'b1; check_bits = 37'({$urandom, $urandom}); check_len = 6'd37;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      n_vec++;
      if ({busy_v[u], done_v[u], match_v[u], lerr_v[u], rem_v[u]} !== 20'h0) begin
        n_err++;
        $display("FAIL reset_mid dut%0d outputs got %b%b%b%b/%h want all 0", u,
                 busy_v[u], done_v[u], match_v[u], lerr_v[u], rem_v[u]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    run_frame(37'h10811, 6'd17, "post_reset");
  endtask

  initial begin
    test_reset();
    test_known();
    test_len_err();
    test_random();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
